// File: rtl/axi_master_bridge.sv
// CPU load/store port to single-beat AXI4 master, one transaction at a time.
// Optional AXI_M_ERR_EN adds a sticky mem_err flag for bad RESP or ID.
module axi_master_bridge #(
  parameter logic [3:0] MASTER_ID = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_write,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_busy,
  output logic        mem_err,
  output logic [3:0]  ARID_M,
  output logic [31:0] ARADDR_M,
  output logic [3:0]  ARLEN_M,
  output logic [2:0]  ARSIZE_M,
  output logic [1:0]  ARBURST_M,
  output logic        ARVALID_M,
  input  logic        ARREADY_M,
  input  logic [3:0]  RID_M,
  input  logic [31:0] RDATA_M,
  input  logic [1:0]  RRESP_M,
  input  logic        RLAST_M,
  input  logic        RVALID_M,
  output logic        RREADY_M,
  output logic [3:0]  AWID_M,
  output logic [31:0] AWADDR_M,
  output logic [3:0]  AWLEN_M,
  output logic [2:0]  AWSIZE_M,
  output logic [1:0]  AWBURST_M,
  output logic        AWVALID_M,
  input  logic        AWREADY_M,
  output logic [31:0] WDATA_M,
  output logic [3:0]  WSTRB_M,
  output logic        WLAST_M,
  output logic        WVALID_M,
  input  logic        WREADY_M,
  input  logic [3:0]  BID_M,
  input  logic [1:0]  BRESP_M,
  input  logic        BVALID_M,
  output logic        BREADY_M
);

  typedef enum logic [2:0] {
    IDLE, RADDR, RDATA, WREQ, WRESP, DONE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        awd_q, awd_d;
  logic        wd_q, wd_d;
  logic        aw_hs, w_hs;

  assign aw_hs = AWVALID_M && AWREADY_M;
  assign w_hs  = WVALID_M && WREADY_M;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      awd_q   <= 1'b0;
      wd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      awd_q   <= awd_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    awd_d   = awd_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE: begin
        if (mem_req) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          awd_d   = 1'b0;
          wd_d    = 1'b0;
          state_d = mem_write ? WREQ : RADDR;
        end
      end
      RADDR: begin
        if (ARREADY_M) state_d = RDATA;
      end
      RDATA: begin
        if (RVALID_M) begin
          rdata_d = RDATA_M;
          if (RLAST_M) state_d = DONE;
        end
      end
      WREQ: begin
        // AW and W complete independently, in either order
        if (aw_hs) awd_d = 1'b1;
        if (w_hs)  wd_d  = 1'b1;
        if ((awd_q || aw_hs) && (wd_q || w_hs))
          state_d = WRESP;
      end
      WRESP: begin
        if (BVALID_M) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ARID_M    = MASTER_ID;
  assign ARADDR_M  = addr_q;
  assign ARLEN_M   = 4'd0;
  assign ARSIZE_M  = 3'b010;
  assign ARBURST_M = 2'b01;
  assign ARVALID_M = (state_q == RADDR);
  assign RREADY_M  = (state_q == RDATA);

  assign AWID_M    = MASTER_ID;
  assign AWADDR_M  = addr_q;
  assign AWLEN_M   = 4'd0;
  assign AWSIZE_M  = 3'b010;
  assign AWBURST_M = 2'b01;
  assign AWVALID_M = (state_q == WREQ) && !awd_q;
  assign WDATA_M   = wdata_q;
  assign WSTRB_M   = wstrb_q;
  assign WLAST_M   = 1'b1;
  assign WVALID_M  = (state_q == WREQ) && !wd_q;
  assign BREADY_M  = (state_q == WRESP);

  assign mem_rdata = rdata_q;
  assign mem_done  = (state_q == DONE);
  assign mem_busy  = (state_q != IDLE);

`ifdef AXI_M_ERR_EN
  logic err_q, err_d;
  logic r_bad, b_bad;

  assign r_bad = RVALID_M && RREADY_M &&
                 ((RRESP_M != 2'b00) || (RID_M != MASTER_ID));
  assign b_bad = BVALID_M && BREADY_M &&
                 ((BRESP_M != 2'b00) || (BID_M != MASTER_ID));

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  always_comb begin
    err_d = err_q;
    if (r_bad || b_bad) err_d = 1'b1;
  end

  assign mem_err = err_q;
`else
  logic unused;
  assign unused  = ^{RID_M, RRESP_M, BID_M, BRESP_M};
  assign mem_err = 1'b0;
`endif

endmodule

// File: doc/axi_master_bridge.md
# axi_master_bridge

Converts single-word load/store requests from a CPU memory port into single-beat AXI4 read or write transactions on the master side of the AXI interconnect. It is the initiator counterpart of the SRAM slave wrapper: one outstanding transaction, CPU stalled until completion. One instance is placed per CPU port (IM and DM) inside the CPU wrapper.

## Interface
Parameters:
- `MASTER_ID`, default 4'd0: value driven on ARID_M/AWID_M (`AXI_ID_BITS` wide).

Ports:
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: **synchronous, active-low reset**.
- `mem_req` in 1: request valid; held by the CPU until `mem_done`.
- `mem_write` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data.
- `mem_wstrb` in 4: byte enables, active-high.
- `mem_rdata` out 32: load data, valid while `mem_done`=1, held afterwards.
- `mem_done` out 1: one-cycle completion pulse.
- `mem_busy` out 1: high whenever FSM != IDLE.
- AR channel: `ARID_M` out 4, `ARADDR_M` out 32, `ARLEN_M` out 4, `ARSIZE_M` out 3, `ARBURST_M` out 2, `ARVALID_M` out 1, `ARREADY_M` in 1.
- R channel: `RID_M` in 4, `RDATA_M` in 32, `RRESP_M` in 2, `RLAST_M` in 1, `RVALID_M` in 1, `RREADY_M` out 1.
- AW channel: `AWID_M` out 4, `AWADDR_M` out 32, `AWLEN_M` out 4, `AWSIZE_M` out 3, `AWBURST_M` out 2, `AWVALID_M` out 1, `AWREADY_M` in 1.
- W channel: `WDATA_M` out 32, `WSTRB_M` out 4, `WLAST_M` out 1, `WVALID_M` out 1, `WREADY_M` in 1.
- B channel: `BID_M` in 4, `BRESP_M` in 2, `BVALID_M` in 1, `BREADY_M` out 1.
- `mem_err` out 1: only with `AXI_M_ERR_EN` (see Configuration).

## Operation
- States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE.
- IDLE: if `mem_req`, register addr/wdata/wstrb; go RADDR (`mem_write`=0) or WREQ (`mem_write`=1).
- RADDR: ARVALID_M=1, ARADDR_M=registered addr; on ARREADY_M -> RDATA.
- RDATA: RREADY_M=1; on RVALID_M capture RDATA_M into `mem_rdata`; if RLAST_M=1 -> DONE, else stay (extra beats overwrite; data of the RLAST beat returned).
- WREQ: AWVALID_M and WVALID_M both raised on entry; each drops independently after its own handshake (AW-before-W, W-before-AW and simultaneous all legal); -> WRESP when both have completed.
- WRESP: BREADY_M=1; on BVALID_M -> DONE.
- DONE: `mem_done`=1 for exactly one cycle; `mem_req` ignored; -> IDLE.
- Constant fields: ARLEN/AWLEN=0, ARSIZE/AWSIZE=3'b010, ARBURST/AWBURST=2'b01 (INCR), WLAST_M=1, WSTRB_M=registered `mem_wstrb`, ID=`MASTER_ID`.
- Address/data outputs stable while the corresponding VALID is high (driven from registers).
- RID_M/BID_M are not checked in the base build.

## Timing
- Reset (rst=0 at an edge): state IDLE; ARVALID_M, AWVALID_M, WVALID_M, RREADY_M, BREADY_M, `mem_done`, `mem_busy`, `mem_err` = 0; `mem_rdata`, address, WDATA_M, WSTRB_M registers = 0. Applies mid-transaction: all VALID/READY drop at that edge, transaction abandoned.
- VALID never deasserted before handshake; VALID does not depend combinationally on READY.
- Minimum latency, slave always ready and responding next cycle: req sampled edge 0 -> VALID cycle 1 -> RREADY/BREADY cycle 2 -> `mem_done` cycle 3.
- Back-to-back: next request earliest accepted at the IDLE cycle following DONE (4-cycle minimum per transaction).
- `mem_busy` = 1 from the cycle after acceptance through DONE inclusive.

## Configuration
- `AXI_M_ERR_EN` defined: `mem_err` is a sticky flag set when RRESP_M != 2'b00 on an R handshake, BRESP_M != 2'b00 on a B handshake, or RID_M/BID_M != `MASTER_ID`; cleared only by reset. Transaction still completes normally.
- Undefined: `mem_err` port tied to 0; RRESP/BRESP/ID ignored.

## Test plan
- Load, ready slave: addr=0x0000_0010, RDATA_M=0xDEAD_BEEF next cycle -> ARADDR_M=0x10, ARLEN=0, ARSIZE=2, `mem_done` at cycle 3 with `mem_rdata`=0xDEAD_BEEF.
- Store, W accepted 3 cycles before AW: wdata=0x1234_5678, wstrb=4'b0011 -> WSTRB_M=0011, WLAST_M=1, WVALID drops after W handshake, AWVALID held until AWREADY, single `mem_done` after BVALID.
- Backpressure: ARREADY_M low 5 cycles, RVALID_M low 4 more -> ARVALID/ARADDR stable throughout, `mem_busy`=1, no `mem_done` early.
- `mem_req` held high through DONE -> exactly one transaction per DONE; second one starts only after IDLE.
- Reset asserted in WREQ with AWVALID_M=1 -> all VALID/READY 0 after that edge, state IDLE, no `mem_done`.
- With `AXI_M_ERR_EN`: BRESP_M=2'b10 -> `mem_err`=1, stays 1 over a following OKAY load; without macro `mem_err`=0.
